result_serializer: RTL and testbench
====================================

RESULT_SERIALIZER -- requirements
Module: result_serializer

Interface
REQ-001 Parameter LANE_W, default 32, width of one result lane in bits.
REQ-002 Parameter LANES, default 16, lanes per result block.
REQ-003 Parameter BEAT_LANES, default 4, lanes per output beat; LANES SHALL be an integer multiple of BEAT_LANES.
REQ-004 Port ref_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Port res_in  input  LANE_W*LANES  result block; lane i occupies bits [LANE_W*(i+1)-1 : LANE_W*i].
REQ-007 Port res_valid  input  1  one-cycle strobe qualifying res_in; no backpressure to the producer.
REQ-008 Port beat_out  output  LANE_W*BEAT_LANES  current output beat.
REQ-009 Port beat_valid  output  1  beat_out is valid.
REQ-010 Port beat_ready  input  1  consumer accepts the beat when beat_valid and beat_ready are both high.
REQ-011 Port beat_idx  output  log2(LANES/BEAT_LANES)  index of the current beat within its block.
REQ-012 Port beat_last  output  1  high with the final beat of a block.
REQ-013 Port ovf  output  1  sticky overflow flag.
REQ-014 Port ovf_clr  input  1  synchronous clear of ovf.

Function
REQ-015 Two-entry FIFO of result blocks; res_valid SHALL write res_in when an entry is free.
REQ-016 FSM states: IDLE (FIFO empty, beat_valid=0) and SEND (head block draining); IDLE->SEND when the FIFO becomes non-empty; SEND->IDLE after the last-beat handshake with the FIFO then empty; otherwise SEND continues with the next block with no bubble.
REQ-017 Latency: a block written in cycle N SHALL present beat 0 in cycle N+1 when the FIFO was empty.
REQ-018 Beat k SHALL carry lanes k*BEAT_LANES .. k*BEAT_LANES+BEAT_LANES-1, lowest lane in the lowest bits; beats SHALL be issued in order 0,1,2,...
REQ-019 beat_out, beat_idx and beat_last SHALL hold stable while beat_valid=1 and beat_ready=0.
REQ-020 beat_idx SHALL wrap to 0 after the last beat; beat_last = (beat_idx == LANES/BEAT_LANES-1) and beat_valid.
REQ-021 res_valid with the FIFO full and no last-beat handshake in the same cycle: the block SHALL be dropped and ovf set to 1.
REQ-022 res_valid with the FIFO full and a last-beat handshake in the same cycle: the block SHALL be accepted and ovf SHALL NOT change.
REQ-023 ovf_clr and an overflow in the same cycle: ovf SHALL be 1 (set wins).
REQ-024 Data SHALL pass bit-exact; no arithmetic is performed on lanes.

Reset
REQ-025 While rst_n=0: beat_valid=0, beat_out=0, beat_idx=0, beat_last=0, ovf=0, FIFO empty, FSM in IDLE.
REQ-026 Reset mid-block SHALL discard all buffered and partially sent data; the first block after reset SHALL start at beat 0.

Configuration
REQ-027 Macro RESULT_SER_PARITY_EN: when defined, output port beat_par (1 bit) SHALL equal the XOR of all bits of beat_out while beat_valid=1, and 0 otherwise or in reset; when undefined, the port and its logic SHALL be absent and all other behaviour is unchanged.

Structure
REQ-028 Shared package holds LANE_W, LANES and BEAT_LANES defaults, the beat-count constant, and the FSM state enum.
REQ-029 The two-entry block FIFO SHALL be a sub-module named block_fifo2 (push, pop, full, empty, head data).

Verification
REQ-030 Single block, lane i = i, beat_ready=1 -> beats 0..3 in cycles N+1..N+4 carrying lanes {0-3},{4-7},{8-11},{12-15}; beat_last only in cycle N+4; then IDLE.
REQ-031 Beat 1 stalled 3 cycles by beat_ready=0 -> beat_out/beat_idx=1 held stable across the stall; stream completes intact.
REQ-032 Three blocks strobed on consecutive cycles with beat_ready=0 -> blocks 1 and 2 buffered, block 3 dropped, ovf=1; releasing ready yields 8 beats of blocks 1 and 2 only.
REQ-033 FIFO full, res_valid coincident with the last-beat handshake -> new block accepted, ovf stays 0, 12 beats total follow.
REQ-034 rst_n pulsed low during beat 2 -> all outputs 0 immediately; a new block then starts at beat_idx=0.
REQ-035 With RESULT_SER_PARITY_EN defined, beat of all lanes 0x00000001 -> beat_par=0; lane 0 = 0x00000003, others 0 -> beat_par=0; lane 0 = 0x00000007 -> beat_par=1.

Source files
------------

// File: rtl/result_serializer_pkg.sv
// Shared defaults and FSM state type for the result serializer.
package result_serializer_pkg;

    localparam int LANE_W_DEF     = 32;
    localparam int LANES_DEF      = 16;
    localparam int BEAT_LANES_DEF = 4;
    localparam int BEATS_DEF      = LANES_DEF / BEAT_LANES_DEF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ser_state_e;

endpackage

// File: rtl/result_serializer_block_fifo2.sv
// Two-entry FIFO of whole result blocks. The caller only pushes when an entry
// is free or the head is being popped in the same cycle.
module block_fifo2 #(
    parameter int W = 512
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   cnt_q, cnt_d;

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q ^ push_i;
        rd_ptr_d = rd_ptr_q ^ pop_i;
        cnt_d    = cnt_q + 2'(push_i) - 2'(pop_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/result_serializer.sv
// Splits buffered result blocks into BEAT_LANES-wide beats with valid/ready.
// Optional beat parity output enabled by defining RESULT_SER_PARITY_EN.
module result_serializer
    import result_serializer_pkg::*;
#(
    parameter int LANE_W     = LANE_W_DEF,
    parameter int LANES      = LANES_DEF,
    parameter int BEAT_LANES = BEAT_LANES_DEF,
    localparam int BEATS     = LANES / BEAT_LANES,
    localparam int IDX_W     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                         ref_clk,
    input  logic                         rst_n,
    input  logic [LANE_W*LANES-1:0]      res_in,
    input  logic                         res_valid,
    output logic [LANE_W*BEAT_LANES-1:0] beat_out,
    output logic                         beat_valid,
    input  logic                         beat_ready,
    output logic [IDX_W-1:0]             beat_idx,
    output logic                         beat_last,
    output logic                         ovf,
    input  logic                         ovf_clr
`ifdef RESULT_SER_PARITY_EN
    ,
    output logic                         beat_par
`endif
);

    localparam int BLK_W  = LANE_W * LANES;
    localparam int BEAT_W = LANE_W * BEAT_LANES;

    ser_state_e       state_q, state_d;
    logic [IDX_W-1:0] beat_idx_q, beat_idx_d;
    logic             ovf_q, ovf_d;
    logic             fifo_full, fifo_empty;
    logic [BLK_W-1:0] fifo_head;
    logic             beat_hs, last_hs, push, drop;

    assign beat_hs = beat_valid && beat_ready;
    assign last_hs = beat_hs && beat_last;
    // A full FIFO still accepts when its head leaves in the same cycle.
    assign push    = res_valid && (!fifo_full || last_hs);
    assign drop    = res_valid && fifo_full && !last_hs;

    block_fifo2 #(.W(BLK_W)) u_fifo (
        .clk     (ref_clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (res_in),
        .pop_i   (last_hs),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (push) state_d = ST_SEND;
            ST_SEND: if (last_hs && !push && !fifo_full) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        beat_valid = (state_q == ST_SEND) && !fifo_empty;
        beat_last  = beat_valid && (beat_idx_q == IDX_W'(BEATS - 1));
        beat_out   = '0;
        if (beat_valid) beat_out = fifo_head[int'(beat_idx_q)*BEAT_W +: BEAT_W];
    end

    always_comb begin
        beat_idx_d = beat_idx_q;
        if (last_hs)      beat_idx_d = '0;
        else if (beat_hs) beat_idx_d = beat_idx_q + 1'b1;
        ovf_d = ovf_q;
        if (drop)         ovf_d = 1'b1;
        else if (ovf_clr) ovf_d = 1'b0;
    end

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_idx_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            beat_idx_q <= beat_idx_d;
            ovf_q      <= ovf_d;
        end
    end

    assign beat_idx = beat_idx_q;
    assign ovf      = ovf_q;

`ifdef RESULT_SER_PARITY_EN
    assign beat_par = ^beat_out;
`endif

endmodule

// File: tb/tb_result_serializer.sv
// Directed self-checking bench for result_serializer (default parameters).
module tb_result_serializer;

    localparam int LW = 32;
    localparam int NL = 16;
    localparam int BL = 4;
    localparam int BW = LW * BL;

    logic            clk;
    logic            rst_n;
    logic [LW*NL-1:0] res_in;
    logic            res_valid;
    logic [BW-1:0]   beat_out;
    logic            beat_valid;
    logic            beat_ready;
    logic [1:0]      beat_idx;
    logic            beat_last;
    logic            ovf;
    logic            ovf_clr;
`ifdef RESULT_SER_PARITY_EN
    logic            beat_par;
`endif

    int checks;
    int passes;

    result_serializer dut (
        .ref_clk    (clk),
        .rst_n      (rst_n),
        .res_in     (res_in),
        .res_valid  (res_valid),
        .beat_out   (beat_out),
        .beat_valid (beat_valid),
        .beat_ready (beat_ready),
        .beat_idx   (beat_idx),
        .beat_last  (beat_last),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr)
`ifdef RESULT_SER_PARITY_EN
        ,
        .beat_par   (beat_par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [LW*NL-1:0] make_block(int base);
        logic [LW*NL-1:0] b;
        for (int i = 0; i < NL; i++) b[i*LW +: LW] = LW'(base + i);
        return b;
    endfunction

    function automatic logic [BW-1:0] exp_beat(int base, int k);
        logic [BW-1:0] r;
        for (int j = 0; j < BL; j++) r[j*LW +: LW] = LW'(base + k*BL + j);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; res_valid = 1'b0; res_in = '0; beat_ready = 1'b0; ovf_clr = 1'b0;
        step(); step();
        checks++; if (beat_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", beat_valid); else passes++;
        checks++; if (beat_out !== '0) $display("FAIL reset_out got %h want 0", beat_out); else passes++;
        checks++; if (beat_idx !== 2'd0) $display("FAIL reset_idx got %0d want 0", beat_idx); else passes++;
        checks++; if (beat_last !== 1'b0) $display("FAIL reset_last got %b want 0", beat_last); else passes++;
        checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", ovf); else passes++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_block();
        beat_ready = 1'b1;
        res_in = make_block(0); res_valid = 1'b1;
        step();
        res_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++; if (beat_valid !== 1'b1) $display("FAIL single_valid k=%0d got %b want 1", k, beat_valid); else passes++;
            checks++; if (beat_idx !== 2'(k)) $display("FAIL single_idx got %0d want %0d", beat_idx, k); else passes++;
            checks++; if (beat_out !== exp_beat(0, k)) $display("FAIL single_out k=%0d got %h want %h", k, beat_out, exp_beat(0, k)); else passes++;
            checks++; if (beat_last !== (k == 3)) $display("FAIL single_last k=%0d got %b want %b", k, beat_last, (k == 3)); else passes++;
            step();
        end
        checks++; if (beat_valid !== 1'b0) $display("FAIL single_idle got %b want 0", beat_valid); else passes++;
        checks++; if (beat_idx !== 2'd0) $display("FAIL single_idx_wrap got %0d want 0", beat_idx); else passes++;
    endtask

    task automatic test_stall();
        beat_ready = 1'b1;
        res_in = make_block(100); res_valid = 1'b1;
        step();
        res_valid = 1'b0;
        checks++; if (beat_out !== exp_beat(100, 0)) $display("FAIL stall_b0 got %h want %h", beat_out, exp_beat(100, 0)); else passes++;
        step();
        beat_ready = 1'b0;
        for (int s = 0; s < 4; s++) begin
            checks++; if (beat_idx !== 2'd1 || beat_valid !== 1'b1) $display("FAIL stall_idx s=%0d got %0d/%b want 1/1", s, beat_idx, beat_valid); else passes++;
            checks++; if (beat_out !== exp_beat(100, 1)) $display("FAIL stall_out s=%0d got %h want %h", s, beat_out, exp_beat(100, 1)); else passes++;
            if (s < 3) step();
        end
        beat_ready = 1'b1;
        step();
        checks++; if (beat_idx !== 2'd2 || beat_out !== exp_beat(100, 2)) $display("FAIL stall_b2 got %0d/%h want 2/%h", beat_idx, beat_out, exp_beat(100, 2)); else passes++;
        step();
        checks++; if (beat_last !== 1'b1 || beat_out !== exp_beat(100, 3)) $display("FAIL stall_b3 got %b/%h want 1/%h", beat_last, beat_out, exp_beat(100, 3)); else passes++;
        step();
        checks++; if (beat_valid !== 1'b0) $display("FAIL stall_idle got %b want 0", beat_valid); else passes++;
    endtask

    task automatic test_overflow();
        int bases [2] = '{200, 300};
        beat_ready = 1'b0;
        res_in = make_block(200); res_valid = 1'b1;
        step();
        res_in = make_block(300);
        step();
        // Third block hits a full FIFO; clear asserted together must lose to the set.
        res_in = make_block(400); ovf_clr = 1'b1;
        step();
        res_valid = 1'b0; ovf_clr = 1'b0;
        checks++; if (ovf !== 1'b1) $display("FAIL ovf_set got %b want 1", ovf); else passes++;
        beat_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 4; k++) begin
                checks++; if (beat_valid !== 1'b1 || beat_idx !== 2'(k)) $display("FAIL ovf_drain b=%0d k=%0d got %b/%0d", b, k, beat_valid, beat_idx); else passes++;
                checks++; if (beat_out !== exp_beat(bases[b], k)) $display("FAIL ovf_data b=%0d k=%0d got %h want %h", b, k, beat_out, exp_beat(bases[b], k)); else passes++;
                step();
            end
        end
        checks++; if (beat_valid !== 1'b0) $display("FAIL ovf_idle got %b want 0", beat_valid); else passes++;
        checks++; if (ovf !== 1'b1) $display("FAIL ovf_sticky got %b want 1", ovf); else passes++;
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        checks++; if (ovf !== 1'b0) $display("FAIL ovf_clr got %b want 0", ovf); else passes++;
    endtask

    task automatic test_back_to_back();
        int bases [3] = '{500, 600, 700};
        int beats;
        beats = 0;
        beat_ready = 1'b0;
        res_in = make_block(500); res_valid = 1'b1;
        step();
        res_in = make_block(600);
        step();
        res_valid = 1'b0;
        beat_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 4; k++) begin
                checks++; if (beat_valid !== 1'b1 || beat_idx !== 2'(k) || beat_out !== exp_beat(bases[b], k))
                    $display("FAIL b2b b=%0d k=%0d got %b/%0d/%h want 1/%0d/%h", b, k, beat_valid, beat_idx, beat_out, k, exp_beat(bases[b], k));
                else passes++;
                if (beat_valid === 1'b1) beats++;
                if (b == 0 && k == 3) begin
                    res_in = make_block(700); res_valid = 1'b1;
                end
                step();
                res_valid = 1'b0;
            end
        end
        checks++; if (beats !== 12) $display("FAIL b2b_count got %0d want 12", beats); else passes++;
        checks++; if (ovf !== 1'b0) $display("FAIL b2b_ovf got %b want 0", ovf); else passes++;
        checks++; if (beat_valid !== 1'b0) $display("FAIL b2b_idle got %b want 0", beat_valid); else passes++;
    endtask

    task automatic test_reset_mid_block();
        beat_ready = 1'b1;
        res_in = make_block(800); res_valid = 1'b1;
        step();
        res_valid = 1'b0;
        step(); step();
        checks++; if (beat_idx !== 2'd2) $display("FAIL rstmid_pre got %0d want 2", beat_idx); else passes++;
        rst_n = 1'b0;
        #1;
        checks++; if (beat_valid !== 1'b0 || beat_out !== '0 || beat_idx !== 2'd0 || beat_last !== 1'b0 || ovf !== 1'b0)
            $display("FAIL rstmid_async got %b/%h/%0d/%b/%b want all 0", beat_valid, beat_out, beat_idx, beat_last, ovf);
        else passes++;
        step();
        rst_n = 1'b1;
        step();
        checks++; if (beat_valid !== 1'b0) $display("FAIL rstmid_flushed got %b want 0", beat_valid); else passes++;
        res_in = make_block(900); res_valid = 1'b1;
        step();
        res_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++; if (beat_valid !== 1'b1 || beat_idx !== 2'(k) || beat_out !== exp_beat(900, k))
                $display("FAIL rstmid_new k=%0d got %b/%0d/%h want 1/%0d/%h", k, beat_valid, beat_idx, beat_out, k, exp_beat(900, k));
            else passes++;
            step();
        end
        checks++; if (beat_valid !== 1'b0) $display("FAIL rstmid_idle got %b want 0", beat_valid); else passes++;
    endtask

`ifdef RESULT_SER_PARITY_EN
    task automatic test_parity();
        logic [LW*NL-1:0] blk;
        logic             want [3] = '{1'b0, 1'b0, 1'b1};
        beat_ready = 1'b1;
        checks++; if (beat_par !== 1'b0) $display("FAIL par_idle got %b want 0", beat_par); else passes++;
        for (int t = 0; t < 3; t++) begin
            blk = '0;
            if (t == 0) for (int i = 0; i < NL; i++) blk[i*LW +: LW] = 32'h1;
            if (t == 1) blk[LW-1:0] = 32'h3;
            if (t == 2) blk[LW-1:0] = 32'h7;
            res_in = blk; res_valid = 1'b1;
            step();
            res_valid = 1'b0;
            checks++; if (beat_par !== want[t]) $display("FAIL par_t%0d got %b want %b", t, beat_par, want[t]); else passes++;
            step(); step(); step(); step();
        end
    endtask
`endif

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_single_block();
        test_stall();
        test_overflow();
        test_back_to_back();
        test_reset_mid_block();
`ifdef RESULT_SER_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
